dot_accumulator: RTL
====================

# dot_accumulator

Downstream consumer of the 2x2 multiplier stage in the matrix-multiply datapath. It takes one product per `in_valid` pulse, sums `N` consecutive products into a dot product and emits the sum with a one-cycle `sum_valid` pulse. It also tags each sum with its result-matrix position and flags the last element of each matrix. Its `in_valid` connects directly to the multiplier's `done`, and its `prod` input to the multiplier's `result`.

## Interface
Parameters:
- `PW`, 4: product width; matches multiplier `result`.
- `N`, 2: products per dot product (inner dimension); must be ≥1.
- `M`, 4: dot products per result matrix (rows×cols); must be ≥1.
- `AW`, 8: accumulator and sum width; must be ≥`PW`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `prod`, in, `PW`: unsigned product from the multiplier.
- `in_valid`, in, 1: `prod` is valid this cycle; every high cycle counts as one product.
- `clear`, in, 1: abort the current partial dot product.
- `sum`, out, `AW`: completed dot product.
- `sum_valid`, out, 1: one-cycle pulse; `sum`, `out_idx`, `mat_done` and `sat` are valid.
- `out_idx`, out, `$clog2(M)` (min 1): matrix element index of `sum`.
- `mat_done`, out, 1: high with `sum_valid` when `out_idx == M-1`.
- `sat`, out, 1: `sum` was clamped (only with the macro; otherwise constant 0).
- `busy`, out, 1: a partial dot product is held (state ACCUM).

## Operation
- Operands are unsigned and zero-extended to `AW`. `acc_next = acc + prod`.
- FSM states are IDLE and ACCUM. A term counter `cnt` runs 0..N-1.
- **IDLE, `in_valid`=1:**
  - If `N==1`: emit `prod` immediately and stay in IDLE.
  - Otherwise: `acc <= prod`, `cnt <= 1`, go to ACCUM.
- **ACCUM, `in_valid`=1, `cnt < N-1`:** `acc <= acc_next`, `cnt++`.
- **ACCUM, `in_valid`=1, `cnt == N-1`:** emit `acc_next`, then `acc <= 0`, `cnt <= 0`, go to IDLE.
- **Emit:** registers `sum`, pulses `sum_valid`, presents the current index counter on `out_idx`, sets `mat_done` if `idx == M-1`, then advances `idx` (wraps M-1 → 0).
- **`clear`=1:**
  - `acc` and `cnt` go to 0 and the FSM goes to IDLE.
  - `in_valid` in the same cycle is discarded.
  - `idx` is unchanged. No emit occurs.
- **`reset`=1:** all state is cleared, including `idx`. `reset` has priority over `clear`.
- `sum` holds its last value between pulses. `sum_valid`, `mat_done` and `sat` are low except in pulse cycles.

## Timing
- Reset values: `sum`=0, `sum_valid`=0, `out_idx`=0, `mat_done`=0, `sat`=0, `busy`=0, `acc`=0, `cnt`=0, `idx`=0.
- Latency: `sum_valid` rises on the clock edge after the cycle in which the N-th `in_valid` is sampled, i.e. 1 cycle.
- Back-to-back operation: `in_valid` may be high every cycle. Dot product k+1 may start in the cycle right after the last term of k, with no bubble and no backpressure.
- Simultaneous `clear` and a final term: `clear` wins and no sum is emitted.
- Reset asserted mid-accumulation: the partial sum is lost, and the next `in_valid` after reset starts term 0 at `idx` 0.
- `busy` is a registered state decode: high the cycle after the first term, low the cycle after the last term.

## Configuration
- Macro: `ACC_SATURATE_EN`.
- **Defined:**
  - Accumulation is computed at `AW+1` bits.
  - On carry-out, `acc` clamps to 2^AW−1 and a sticky `sat_flag` is set.
  - `sat_flag` clears on emit, `clear` and `reset`.
  - `sat` outputs the flag (including overflow on the final term) together with `sum_valid`.
- **Undefined:**
  - Accumulation wraps modulo 2^AW.
  - `sat` is tied to 0.
  - No extra logic is generated.

## Structure
- Shared package `mm_pkg`:
  - FSM state enum `acc_state_t` {IDLE, ACCUM}.
  - Default widths `MM_PW`=4, `MM_AW`=8.
  - Default dimensions `MM_N`=2, `MM_M`=4.
- One sub-module, `mod_counter` (parameters `MOD`, `W`; inputs `inc`, `clr`; outputs `val`, `wrap`). It is instantiated twice: the term counter (`MOD`=N) and the index counter (`MOD`=M).

## Test plan
1. **Basic sum.** N=2, AW=8: `prod` 9 then 9 on consecutive `in_valid` cycles → next cycle `sum`=18, `sum_valid`=1, `out_idx`=0, `sat`=0.
2. **Back-to-back.** N=2: `in_valid` continuous with `prod` 3,4,5,6 → `sum`=7 (`out_idx` 0), then `sum`=11 (`out_idx` 1) two cycles later. No missed or merged terms.
3. **Index wrap.** M=4: six dot products of 1+1 → `out_idx` 0,1,2,3,0,1. `mat_done`=1 only on the 4th. Every `sum`=2.
4. **Clear mid-op.** `prod` 7, then `clear`=1 with `in_valid`=1 (`prod` 5), then 2 and 3 → a single `sum`=5. `out_idx` unchanged by the clear.
5. **Reset mid-op.** `prod` 15, then `reset` for 1 cycle, then 1 and 2 → `sum`=3, `out_idx`=0. All outputs are at reset values during reset.
6. **Overflow.** AW=4, N=2, `prod` 9 and 9:
   - With `ACC_SATURATE_EN`: `sum`=15, `sat`=1.
   - Without it: `sum`=2, `sat`=0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and default dimensions for the matrix-multiply datapath.
package mm_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  localparam int MM_PW = 4;
  localparam int MM_AW = 8;
  localparam int MM_N  = 2;
  localparam int MM_M  = 4;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter; wrap flags the increment that rolls over to 0.
module mod_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] val,
  output logic         wrap
);

  logic at_top;

  assign at_top = (val == W'(MOD - 1));
  assign wrap   = inc && at_top;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      val <= '0;
    end else if (inc) begin
      val <= at_top ? '0 : val + 1'b1;
    end
  end

endmodule

// File: rtl/dot_accumulator.sv
// Sums N products per dot product, tags each with its matrix index.
// Optional clamp-on-overflow via ACC_SATURATE_EN.
module dot_accumulator
  import mm_pkg::*;
#(
  parameter  int PW = MM_PW,
  parameter  int N  = MM_N,
  parameter  int M  = MM_M,
  parameter  int AW = MM_AW,
  localparam int NW = cw(N),
  localparam int IW = cw(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] prod,
  input  logic          in_valid,
  input  logic          clear,
  output logic [AW-1:0] sum,
  output logic          sum_valid,
  output logic [IW-1:0] out_idx,
  output logic          mat_done,
  output logic          sat,
  output logic          busy
);

  acc_state_t    state;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] prod_ext;
  logic [NW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          take;
  logic          emit;
  logic          term_wrap;
  logic          idx_wrap;

  assign prod_ext = AW'(prod);
  assign take     = in_valid && !clear;
  assign emit     = take && term_wrap;
  assign busy     = (state == ACCUM);

  mod_counter #(.MOD(N), .W(NW)) u_term (
    .clk   (clk),
    .reset (reset),
    .inc   (take),
    .clr   (clear),
    .val   (cnt),
    .wrap  (term_wrap)
  );

  mod_counter #(.MOD(M), .W(IW)) u_idx (
    .clk   (clk),
    .reset (reset),
    .inc   (emit),
    .clr   (1'b0),
    .val   (idx),
    .wrap  (idx_wrap)
  );

`ifdef ACC_SATURATE_EN
  logic [AW:0] acc_wide;
  logic        ovf;
  logic        sat_flag;

  assign acc_wide = {1'b0, acc} + {1'b0, prod_ext};
  assign ovf      = acc_wide[AW];
  assign acc_next = ovf ? '1 : acc_wide[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag <= 1'b0;
      sat      <= 1'b0;
    end else begin
      sat <= 1'b0;
      if (clear) begin
        sat_flag <= 1'b0;
      end else if (emit) begin
        sat      <= sat_flag | ovf;
        sat_flag <= 1'b0;
      end else if (take) begin
        sat_flag <= sat_flag | ovf;
      end
    end
  end
`else
  assign acc_next = acc + prod_ext;
  assign sat      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      out_idx   <= '0;
      mat_done  <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      mat_done  <= 1'b0;
      if (clear) begin
        state <= IDLE;
        acc   <= '0;
      end else if (emit) begin
        state     <= IDLE;
        acc       <= '0;
        sum       <= acc_next;
        sum_valid <= 1'b1;
        out_idx   <= idx;
        mat_done  <= idx_wrap;
      end else if (take) begin
        state <= ACCUM;
        acc   <= acc_next;
      end
    end
  end

  // A partial dot product exists exactly when terms have been counted.
  assert property (@(posedge clk) disable iff (reset)
    (state == ACCUM) == (cnt != '0));

endmodule
